// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use bubble insertion, taken-branch squash,
// data-memory freeze and saturating hazard event counters.
module id_ex_hazard_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [XLEN-1:0]  ID_pc,
  input  logic [XLEN-1:0]  ID_rs1_data,
  input  logic [XLEN-1:0]  ID_rs2_data,
  input  logic [XLEN-1:0]  ID_imm,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [4:0]       ID_rd,
  input  logic             ID_uses_rs1,
  input  logic             ID_uses_rs2,
  input  logic             ID_reg_write,
  input  logic             ID_mem_read,
  input  logic             ID_mem_write,
  input  logic             ID_branch,
  input  logic             ID_alu_src_b,
  input  logic             ID_auipc,
  input  logic [1:0]       ID_mem_to_reg,
  input  logic [3:0]       ID_alu_op,
  input  logic             ID_valid,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic [XLEN-1:0]  ID_EX_pc,
  output logic [XLEN-1:0]  ID_EX_rs1_data,
  output logic [XLEN-1:0]  ID_EX_rs2_data,
  output logic [XLEN-1:0]  ID_EX_imm,
  output logic [4:0]       ID_EX_rs1,
  output logic [4:0]       ID_EX_rs2,
  output logic [4:0]       ID_EX_rd,
  output logic             ID_EX_uses_rs1,
  output logic             ID_EX_uses_rs2,
  output logic             ID_EX_reg_write,
  output logic             ID_EX_mem_read,
  output logic             ID_EX_mem_write,
  output logic             ID_EX_branch,
  output logic             ID_EX_alu_src_b,
  output logic             ID_EX_auipc,
  output logic [1:0]       ID_EX_mem_to_reg,
  output logic [3:0]       ID_EX_alu_op,
  output logic             ID_EX_valid,
  output logic             stall_front,
  output logic             flush_if_id,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            alu_src_b;
    logic            auipc;
    logic [1:0]      mem_to_reg;
    logic [3:0]      alu_op;
    logic            valid;
  } id_ex_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  id_ex_t           id_in;
  id_ex_t           id_ex_d, id_ex_q;
  logic [CNT_W-1:0] lu_cnt_d, lu_cnt_q;
  logic [CNT_W-1:0] fl_cnt_d, fl_cnt_q;
  logic             lu, bt;

  assign id_in = '{pc: ID_pc, rs1_data: ID_rs1_data, rs2_data: ID_rs2_data,
                   imm: ID_imm, rs1: ID_rs1, rs2: ID_rs2, rd: ID_rd,
                   uses_rs1: ID_uses_rs1, uses_rs2: ID_uses_rs2,
                   reg_write: ID_reg_write, mem_read: ID_mem_read,
                   mem_write: ID_mem_write, branch: ID_branch,
                   alu_src_b: ID_alu_src_b, auipc: ID_auipc,
                   mem_to_reg: ID_mem_to_reg, alu_op: ID_alu_op,
                   valid: ID_valid};

  // A load targeting x0 never produces a value worth waiting for.
  assign lu = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != 5'd0) && ID_valid &&
              ((ID_uses_rs1 && (ID_rs1 == id_ex_q.rd)) ||
               (ID_uses_rs2 && (ID_rs2 == id_ex_q.rd)));
  assign bt = branch_taken && id_ex_q.valid;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    id_ex_d     = id_ex_q;
    lu_cnt_d    = lu_cnt_q;
    fl_cnt_d    = fl_cnt_q;
    stall_front = 1'b0;
    flush_if_id = 1'b0;
    if (mem_busy) begin
      stall_front = 1'b1;
    end else if (bt) begin
      id_ex_d     = '0;
      flush_if_id = 1'b1;
      if (fl_cnt_q != CNT_MAX) fl_cnt_d = fl_cnt_q + 1'b1;
    end else if (lu) begin
      id_ex_d     = '0;
      stall_front = 1'b1;
      if (lu_cnt_q != CNT_MAX) lu_cnt_d = lu_cnt_q + 1'b1;
    end else begin
      id_ex_d = id_in;
    end
    if (!rstn) begin
      stall_front = 1'b0;
      flush_if_id = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    if (!rstn) begin
      id_ex_q  <= '0;
      lu_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      lu_cnt_q <= lu_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  assign ID_EX_pc         = id_ex_q.pc;
  assign ID_EX_rs1_data   = id_ex_q.rs1_data;
  assign ID_EX_rs2_data   = id_ex_q.rs2_data;
  assign ID_EX_imm        = id_ex_q.imm;
  assign ID_EX_rs1        = id_ex_q.rs1;
  assign ID_EX_rs2        = id_ex_q.rs2;
  assign ID_EX_rd         = id_ex_q.rd;
  assign ID_EX_uses_rs1   = id_ex_q.uses_rs1;
  assign ID_EX_uses_rs2   = id_ex_q.uses_rs2;
  assign ID_EX_reg_write  = id_ex_q.reg_write;
  assign ID_EX_mem_read   = id_ex_q.mem_read;
  assign ID_EX_mem_write  = id_ex_q.mem_write;
  assign ID_EX_branch     = id_ex_q.branch;
  assign ID_EX_alu_src_b  = id_ex_q.alu_src_b;
  assign ID_EX_auipc      = id_ex_q.auipc;
  assign ID_EX_mem_to_reg = id_ex_q.mem_to_reg;
  assign ID_EX_alu_op     = id_ex_q.alu_op;
  assign ID_EX_valid      = id_ex_q.valid;
  assign load_use_cnt     = lu_cnt_q;
  assign flush_cnt        = fl_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage; a second narrow-counter instance
// shares the stimulus to reach counter saturation in few cycles.
module tb_id_ex_hazard_stage;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rstn;
  logic [XLEN-1:0] ID_pc, ID_rs1_data, ID_rs2_data, ID_imm;
  logic [4:0] ID_rs1, ID_rs2, ID_rd;
  logic ID_uses_rs1, ID_uses_rs2, ID_reg_write, ID_mem_read, ID_mem_write;
  logic ID_branch, ID_alu_src_b, ID_auipc, ID_valid, branch_taken, mem_busy;
  logic [1:0] ID_mem_to_reg;
  logic [3:0] ID_alu_op;

  logic [XLEN-1:0] ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
  logic [4:0] ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
  logic ID_EX_uses_rs1, ID_EX_uses_rs2, ID_EX_reg_write, ID_EX_mem_read;
  logic ID_EX_mem_write, ID_EX_branch, ID_EX_alu_src_b, ID_EX_auipc, ID_EX_valid;
  logic [1:0] ID_EX_mem_to_reg;
  logic [3:0] ID_EX_alu_op;
  logic stall_front, flush_if_id;
  logic [15:0] load_use_cnt, flush_cnt;

  logic [XLEN-1:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [4:0] s_rs1, s_rs2, s_rd;
  logic s_uses_rs1, s_uses_rs2, s_reg_write, s_mem_read, s_mem_write;
  logic s_branch, s_alu_src_b, s_auipc, s_valid, s_stall_front, s_flush_if_id;
  logic [1:0] s_mem_to_reg;
  logic [3:0] s_alu_op;
  logic [2:0] s_load_use_cnt, s_flush_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_hazard_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn),
    .ID_pc(ID_pc), .ID_rs1_data(ID_rs1_data), .ID_rs2_data(ID_rs2_data), .ID_imm(ID_imm),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
    .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .ID_reg_write(ID_reg_write), .ID_mem_read(ID_mem_read), .ID_mem_write(ID_mem_write),
    .ID_branch(ID_branch), .ID_alu_src_b(ID_alu_src_b), .ID_auipc(ID_auipc),
    .ID_mem_to_reg(ID_mem_to_reg), .ID_alu_op(ID_alu_op), .ID_valid(ID_valid),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .ID_EX_pc(ID_EX_pc), .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
    .ID_EX_imm(ID_EX_imm), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
    .ID_EX_uses_rs1(ID_EX_uses_rs1), .ID_EX_uses_rs2(ID_EX_uses_rs2),
    .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_mem_read(ID_EX_mem_read),
    .ID_EX_mem_write(ID_EX_mem_write), .ID_EX_branch(ID_EX_branch),
    .ID_EX_alu_src_b(ID_EX_alu_src_b), .ID_EX_auipc(ID_EX_auipc),
    .ID_EX_mem_to_reg(ID_EX_mem_to_reg), .ID_EX_alu_op(ID_EX_alu_op),
    .ID_EX_valid(ID_EX_valid), .stall_front(stall_front), .flush_if_id(flush_if_id),
    .load_use_cnt(load_use_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_hazard_stage #(.XLEN(XLEN), .CNT_W(3)) dut_small (
    .clk(clk), .rstn(rstn),
    .ID_pc(ID_pc), .ID_rs1_data(ID_rs1_data), .ID_rs2_data(ID_rs2_data), .ID_imm(ID_imm),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
    .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .ID_reg_write(ID_reg_write), .ID_mem_read(ID_mem_read), .ID_mem_write(ID_mem_write),
    .ID_branch(ID_branch), .ID_alu_src_b(ID_alu_src_b), .ID_auipc(ID_auipc),
    .ID_mem_to_reg(ID_mem_to_reg), .ID_alu_op(ID_alu_op), .ID_valid(ID_valid),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .ID_EX_pc(s_pc), .ID_EX_rs1_data(s_rs1_data), .ID_EX_rs2_data(s_rs2_data),
    .ID_EX_imm(s_imm), .ID_EX_rs1(s_rs1), .ID_EX_rs2(s_rs2), .ID_EX_rd(s_rd),
    .ID_EX_uses_rs1(s_uses_rs1), .ID_EX_uses_rs2(s_uses_rs2),
    .ID_EX_reg_write(s_reg_write), .ID_EX_mem_read(s_mem_read),
    .ID_EX_mem_write(s_mem_write), .ID_EX_branch(s_branch),
    .ID_EX_alu_src_b(s_alu_src_b), .ID_EX_auipc(s_auipc),
    .ID_EX_mem_to_reg(s_mem_to_reg), .ID_EX_alu_op(s_alu_op),
    .ID_EX_valid(s_valid), .stall_front(s_stall_front), .flush_if_id(s_flush_if_id),
    .load_use_cnt(s_load_use_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one decoded instruction; data fields are derived from pc.
  task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic u1, input logic u2,
                       input logic mr, input logic rw, input logic v);
    ID_pc = pc; ID_rs1_data = pc + 32'd1; ID_rs2_data = pc + 32'd2; ID_imm = pc + 32'd3;
    ID_rs1 = rs1; ID_rs2 = rs2; ID_rd = rd;
    ID_uses_rs1 = u1; ID_uses_rs2 = u2; ID_mem_read = mr; ID_reg_write = rw;
    ID_mem_write = 1'b0; ID_branch = 1'b0; ID_alu_src_b = 1'b1; ID_auipc = 1'b0;
    ID_mem_to_reg = mr ? 2'b11 : 2'b00; ID_alu_op = 4'h2; ID_valid = v;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; mem_busy = 1'b1; branch_taken = 1'b1;
    drive(32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); step();
    check("rst_stall", stall_front, 1'b0);
    check("rst_flush", flush_if_id, 1'b0);
    check("rst_valid", ID_EX_valid, 1'b0);
    check("rst_pc", ID_EX_pc, 32'h0);
    check("rst_lucnt", load_use_cnt, 16'd0);
    check("rst_flcnt", flush_cnt, 16'd0);
    rstn = 1'b1; mem_busy = 1'b0; branch_taken = 1'b0;

    // Load-use stall on rs1
    drive(32'h10, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check("lw_nostall", stall_front, 1'b0);
    step();
    check("lw_pc", ID_EX_pc, 32'h10);
    check("lw_rd", ID_EX_rd, 5'd5);
    check("lw_mr", ID_EX_mem_read, 1'b1);
    check("lw_m2r", ID_EX_mem_to_reg, 2'b11);
    drive(32'h14, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("lu_stall", stall_front, 1'b1);
    check("lu_flush", flush_if_id, 1'b0);
    step();
    check("lu_bub_valid", ID_EX_valid, 1'b0);
    check("lu_bub_rd", ID_EX_rd, 5'd0);
    check("lu_bub_rw", ID_EX_reg_write, 1'b0);
    check("lu_bub_m2r", ID_EX_mem_to_reg, 2'b00);
    check("lu_bub_data", ID_EX_rs1_data, 32'h0);
    check("lu_cnt1", load_use_cnt, 16'd1);
    check("lu_stall_clr", stall_front, 1'b0);
    step();
    check("lu_add_rs1", ID_EX_rs1, 5'd5);
    check("lu_add_valid", ID_EX_valid, 1'b1);
    check("lu_add_pc", ID_EX_pc, 32'h14);
    check("lu_add_imm", ID_EX_imm, 32'h17);

    // rs2 matches but is not used
    drive(32'h20, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    drive(32'h24, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("nors2_stall", stall_front, 1'b0);
    step();
    check("nors2_pc", ID_EX_pc, 32'h24);
    check("nors2_cnt", load_use_cnt, 16'd1);

    // rs2 used and matching
    drive(32'h30, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    drive(32'h34, 5'd1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rs2_stall", stall_front, 1'b1);
    step();
    check("rs2_cnt", load_use_cnt, 16'd2);
    check("rs2_bub", ID_EX_valid, 1'b0);
    step();
    check("rs2_pc", ID_EX_pc, 32'h34);

    // Load into x0
    drive(32'h40, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    drive(32'h44, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("x0_stall", stall_front, 1'b0);
    step();
    check("x0_pc", ID_EX_pc, 32'h44);

    // LUI after load: indices match but neither is read
    drive(32'h50, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    drive(32'h54, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("lui_stall", stall_front, 1'b0);
    step();
    check("lui_pc", ID_EX_pc, 32'h54);

    // Dependent but IF/ID empty
    drive(32'h60, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    drive(32'h64, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("idinv_stall", stall_front, 1'b0);
    step();
    check("idinv_valid", ID_EX_valid, 1'b0);
    check("idinv_cnt", load_use_cnt, 16'd2);

    // Branch and load-use together
    drive(32'h70, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    drive(32'h74, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    branch_taken = 1'b1; #1;
    check("bt_flush", flush_if_id, 1'b1);
    check("bt_stall", stall_front, 1'b0);
    step();
    branch_taken = 1'b0;
    check("bt_bub", ID_EX_valid, 1'b0);
    check("bt_flcnt", flush_cnt, 16'd1);
    check("bt_lucnt", load_use_cnt, 16'd2);

    // Branch pulse with an empty ID_EX is ignored
    drive(32'h80, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    branch_taken = 1'b1; #1;
    check("btinv_flush", flush_if_id, 1'b0);
    step();
    branch_taken = 1'b0;
    check("btinv_pc", ID_EX_pc, 32'h80);
    check("btinv_flcnt", flush_cnt, 16'd1);

    // Memory freeze for 3 cycles, one with a branch pulse
    drive(32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    check("frz_pc0", ID_EX_pc, 32'h100);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h200 + 32'(i * 4), 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      branch_taken = (i == 1); #1;
      check("frz_stall", stall_front, 1'b1);
      check("frz_flush", flush_if_id, 1'b0);
      step();
      check("frz_pc", ID_EX_pc, 32'h100);
    end
    check("frz_flcnt", flush_cnt, 16'd1);
    mem_busy = 1'b0; branch_taken = 1'b0;
    drive(32'h300, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("rel_stall", stall_front, 1'b0);
    step();
    check("rel_pc", ID_EX_pc, 32'h300);

    // Freeze with a load-use pending, then release
    drive(32'h400, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    mem_busy = 1'b1;
    drive(32'h404, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check("frzlu_pc", ID_EX_pc, 32'h400);
    check("frzlu_cnt", load_use_cnt, 16'd2);
    mem_busy = 1'b0; #1;
    check("frzlu_stall", stall_front, 1'b1);
    step();
    check("frzlu_cnt2", load_use_cnt, 16'd3);
    check("frzlu_bub", ID_EX_valid, 1'b0);
    step();
    check("frzlu_add", ID_EX_pc, 32'h404);

    // Reset during a freeze
    drive(32'h500, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    check("rfz_rd", ID_EX_rd, 5'd7);
    mem_busy = 1'b1;
    step();
    rstn = 1'b0; #1;
    check("rfz_stall", stall_front, 1'b0);
    step();
    check("rfz_valid", ID_EX_valid, 1'b0);
    check("rfz_rd0", ID_EX_rd, 5'd0);
    check("rfz_rw", ID_EX_reg_write, 1'b0);
    check("rfz_pc", ID_EX_pc, 32'h0);
    check("rfz_lucnt", load_use_cnt, 16'd0);
    check("rfz_flcnt", flush_cnt, 16'd0);
    rstn = 1'b1; mem_busy = 1'b0;

    // Counter saturation on the 3-bit instance
    for (int i = 0; i < 10; i++) begin
      drive(32'h600 + 32'(i * 4), 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      step();
      branch_taken = 1'b1; #1;
      check("sat_flush", flush_if_id, 1'b1);
      step();
      branch_taken = 1'b0;
    end
    check("sat_flcnt16", flush_cnt, 16'd10);
    check("sat_flcnt3", s_flush_cnt, 3'd7);
    check("sat_lucnt3", s_load_use_cnt, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
